pmp_seq_checker: RTL

- Iterative PMP checker that time-multiplexes one pmpadrdec instance across all PMP entries, one entry per cycle, instead of replicating the decoder N times.
- Used where PMP checks are off the critical path, e.g. the hardware page-table walker and debug or system bus ports. Area is traded for multi-cycle latency.
- Implements lowest-numbered-match priority and carries the TOR lower-bound compare between consecutive entries in a register.

---
 rtl/pmp_pkg.sv | 19 +
 rtl/pmpadrdec.sv | 62 ++++++
 rtl/pmp_seq_checker.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pmp_pkg.sv
// Shared definitions for the PMP address decoder and the sequential PMP checker.
package pmp_pkg;

    localparam logic [1:0] PMP_A_OFF   = 2'b00;
    localparam logic [1:0] PMP_A_TOR   = 2'b01;
    localparam logic [1:0] PMP_A_NA4   = 2'b10;
    localparam logic [1:0] PMP_A_NAPOT = 2'b11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } pmp_seq_state_t;

endpackage

// File: rtl/pmpadrdec.sv
// Single PMP entry address decoder: TOR, NA4 and NAPOT matching plus the
// "address >= pmpaddr" term that serves as the next entry's TOR lower bound.
module pmpadrdec
    import pmp_pkg::*;
#(
    parameter int PA_BITS = 56
) (
    input  logic [PA_BITS-1:0] PhysicalAddress,
    input  logic [1:0]         Size,
    input  logic [7:0]         PMPCfg,
    input  logic [PA_BITS-3:0] PMPAdr,
    input  logic               PAgePMPAdrIn,
    output logic               PAgePMPAdrOut,
    output logic               Match,
    output logic               Active,
    output logic               L,
    output logic               X,
    output logic               W,
    output logic               R
);

    localparam logic [PA_BITS-3:0] ADR_ONE = {{(PA_BITS-3){1'b0}}, 1'b1};

    logic [1:0]         w_adrMode;
    logic [PA_BITS-1:0] w_base;
    logic [PA_BITS-3:0] w_adrPlusOne;
    logic [PA_BITS-1:0] w_mask;
    logic               w_belowAdr;
    logic               w_regionMatch;
    logic               w_unusedCfg;

    assign w_adrMode    = PMPCfg[4:3];
    assign w_base       = {PMPAdr, 2'b00};
    assign w_adrPlusOne = PMPAdr + ADR_ONE;
    assign w_belowAdr   = PhysicalAddress < w_base;
    assign w_unusedCfg  = ^PMPCfg[6:5];

    // NAPOT: trailing ones of pmpaddr plus the two implied low bits form the
    // don't-care mask; NA4 is a fixed 4-byte granule.
    assign w_mask = (w_adrMode == PMP_A_NA4) ? {{(PA_BITS-2){1'b0}}, 2'b11}
                                             : {PMPAdr ^ w_adrPlusOne, 2'b11};
    assign w_regionMatch = ((PhysicalAddress ^ w_base) & ~w_mask) == '0;

    assign PAgePMPAdrOut = ~w_belowAdr;
    assign Active        = w_adrMode != PMP_A_OFF;
    assign L             = PMPCfg[7];
    assign X             = PMPCfg[2];
    assign W             = PMPCfg[1];
    assign R             = PMPCfg[0];

    // An NA4 granule cannot contain an access wider than 4 bytes.
    always_comb begin
        Match = 1'b0;
        case (w_adrMode)
            PMP_A_TOR:   Match = PAgePMPAdrIn & w_belowAdr;
            PMP_A_NA4:   Match = w_regionMatch & (Size != 2'b11);
            PMP_A_NAPOT: Match = w_regionMatch;
            default:     Match = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_seq_checker.sv
// Iterative PMP checker: one shared pmpadrdec walks the entries one per cycle,
// first match wins, and the TOR lower-bound compare is carried in a register.
module pmp_seq_checker
    import pmp_pkg::*;
#(
    parameter int PMP_ENTRIES = 16,
    parameter int PA_BITS     = 56,
    parameter int IDX_BITS    = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              CheckReq,
    output logic                              CheckReady,
    input  logic [PA_BITS-1:0]                PhysicalAddress,
    input  logic [1:0]                        Size,
    input  logic                              ReadAccess,
    input  logic                              WriteAccess,
    input  logic                              ExecuteAccess,
    input  logic [1:0]                        PrivilegeMode,
    input  logic [8*PMP_ENTRIES-1:0]          PMPCfgFlat,
    input  logic [(PA_BITS-2)*PMP_ENTRIES-1:0] PMPAdrFlat,
    input  logic                              PMPCfgWrite,
    input  logic                              Flush,
    output logic                              CheckDone,
    output logic                              PMPMatch,
    output logic [IDX_BITS-1:0]               MatchIdx,
    output logic                              LoadAccessFault,
    output logic                              StoreAccessFault,
    output logic                              InstrAccessFault
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(PMP_ENTRIES - 1);
    localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

    pmp_seq_state_t r_state, w_nextState;

    logic [IDX_BITS-1:0] r_idx;
    logic                r_pageCarry;
    logic                r_anyActive;
    logic [PA_BITS-1:0]  r_addr;
    logic [1:0]          r_size;
    logic                r_read, r_write, r_exec;
    logic [1:0]          r_priv;
    logic                r_match;
    logic [IDX_BITS-1:0] r_matchIdx;
    logic                r_loadFault, r_storeFault, r_instrFault;

    logic [7:0]          w_entryCfg;
    logic [PA_BITS-3:0]  w_entryAdr;
    logic                w_pageOut, w_match, w_active, w_l, w_x, w_w, w_r;
    logic                w_lastIdx, w_scanEnd, w_restart, w_step, w_accept;
    logic                w_isM, w_anyActiveNext;
    logic                w_loadFault, w_storeFault, w_instrFault;

    always_comb begin
        w_entryCfg = '0;
        w_entryAdr = '0;
        for (int i = 0; i < PMP_ENTRIES; i++) begin
            if (r_idx == IDX_BITS'(i)) begin
                w_entryCfg = PMPCfgFlat[8*i +: 8];
                w_entryAdr = PMPAdrFlat[(PA_BITS-2)*i +: (PA_BITS-2)];
            end
        end
    end

    pmpadrdec #(.PA_BITS(PA_BITS)) u_pmpadrdec (
        .PhysicalAddress (r_addr),
        .Size            (r_size),
        .PMPCfg          (w_entryCfg),
        .PMPAdr          (w_entryAdr),
        .PAgePMPAdrIn    (r_pageCarry),
        .PAgePMPAdrOut   (w_pageOut),
        .Match           (w_match),
        .Active          (w_active),
        .L               (w_l),
        .X               (w_x),
        .W               (w_w),
        .R               (w_r)
    );

    assign w_lastIdx = r_idx == LAST_IDX;
    assign w_accept  = (r_state == IDLE) & CheckReq;
    assign w_restart = (r_state == SCAN) & PMPCfgWrite & ~Flush;
    assign w_scanEnd = (r_state == SCAN) & ~Flush & ~PMPCfgWrite & (w_match | w_lastIdx);
    assign w_step    = (r_state == SCAN) & ~Flush & ~PMPCfgWrite & ~w_match & ~w_lastIdx;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (CheckReq) w_nextState = SCAN;
            SCAN: begin
                if (Flush)                       w_nextState = IDLE;
                else if (PMPCfgWrite)            w_nextState = SCAN;
                else if (w_match || w_lastIdx)   w_nextState = DONE;
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    // Machine mode bypasses unlocked matching entries; with no match only
    // lower privileges fault, and only if some entry was configured.
    assign w_isM           = r_priv == PRIV_M;
    assign w_anyActiveNext = r_anyActive | w_active;

    always_comb begin
        w_loadFault  = 1'b0;
        w_storeFault = 1'b0;
        w_instrFault = 1'b0;
        if (w_match) begin
            if (!(w_isM && !w_l)) begin
                w_loadFault  = r_read  & ~w_r;
                w_storeFault = r_write & ~w_w;
                w_instrFault = r_exec  & ~w_x;
            end
        end else begin
            w_loadFault  = r_read  & ~w_isM & w_anyActiveNext;
            w_storeFault = r_write & ~w_isM & w_anyActiveNext;
            w_instrFault = r_exec  & ~w_isM & w_anyActiveNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx        <= '0;
            r_pageCarry  <= 1'b1;
            r_anyActive  <= 1'b0;
            r_addr       <= '0;
            r_size       <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_exec       <= 1'b0;
            r_priv       <= '0;
            r_match      <= 1'b0;
            r_matchIdx   <= '0;
            r_loadFault  <= 1'b0;
            r_storeFault <= 1'b0;
            r_instrFault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= PhysicalAddress;
                r_size      <= Size;
                r_read      <= ReadAccess;
                r_write     <= WriteAccess;
                r_exec      <= ExecuteAccess;
                r_priv      <= PrivilegeMode;
                r_idx       <= '0;
                r_pageCarry <= 1'b1;
                r_anyActive <= 1'b0;
            end else if (w_restart) begin
                r_idx       <= '0;
                r_pageCarry <= 1'b1;
                r_anyActive <= 1'b0;
            end else if (w_step) begin
                r_idx       <= r_idx + IDX_ONE;
                r_pageCarry <= w_pageOut;
                r_anyActive <= w_anyActiveNext;
            end
            if (w_scanEnd) begin
                r_match      <= w_match;
                r_matchIdx   <= w_match ? r_idx : '0;
                r_loadFault  <= w_loadFault;
                r_storeFault <= w_storeFault;
                r_instrFault <= w_instrFault;
            end
        end
    end

    assign CheckReady       = r_state == IDLE;
    assign CheckDone        = (r_state == DONE) & ~Flush;
    assign PMPMatch         = r_match;
    assign MatchIdx         = r_matchIdx;
    assign LoadAccessFault  = r_loadFault;
    assign StoreAccessFault = r_storeFault;
    assign InstrAccessFault = r_instrFault;

endmodule
